seven_segment_8digit_mux: RTL and testbench
===========================================

Name: seven_segment_8digit_mux

Overview:
Time-multiplexed driver for the Nexys4 8-digit common-anode seven-segment display. It consumes a 32-bit hex value plus per-digit enable and decimal-point masks from the board top level. It drives the active-low seg/dp/an pins by scanning one digit per slot. It replaces the constant "display off" tie-offs in the board top with a live display stage.

Parameters:
- DIGIT_PERIOD, 100000, clock cycles per digit slot (1 kHz per digit, 125 Hz refresh at 100 MHz clk); legal range ≥ 2.
- GUARD_CYCLES, 16, number of blanking cycles at the start of each slot (only used with the optional feature); must be < DIGIT_PERIOD.

Ports:
- clk  input  1  system clock (100 MHz on board).
- reset  input  1  synchronous, active-high reset.
- number  input  32  hex value to show; nibble i → digit i (digit 0 = rightmost).
- digit_en  input  8  1 = digit i lit; 0 = digit i blank.
- dot  input  8  1 = decimal point of digit i lit.
- seg  output  7  segment cathodes CA..CG as seg[0]..seg[6], active-low.
- dp  output  1  decimal-point cathode, active-low.
- an  output  8  digit anodes, active-low, one-hot-low when lit.

Behaviour:
- Reset (synchronous, checked every edge, overrides everything, including mid-slot):
  - cnt ← 0, digit ← 0, frame registers ← 0.
  - an ← 8'hFF, seg ← 7'h7F, dp ← 1.
- Slot counter: cnt counts 0..DIGIT_PERIOD-1. At DIGIT_PERIOD-1, cnt ← 0 and digit ← digit+1, with modulo-8 wrap 7→0. Width of cnt is $clog2(DIGIT_PERIOD).
- Frame snapshot: on every edge where cnt==0 && digit==0 (including the first edge after reset release), {number, digit_en, dot} are latched into frame registers.
  - All 8 digits of one refresh shown one coherent value.
  - Input changes mid-frame are invisible until the next frame.
- Output registers: each edge computes from the pre-edge (digit, frame) state.
  - an ← ~(8'b1 << digit) if frame_en[digit], else 8'hFF.
  - seg ← ~decode(frame_num[4*digit+:4]) if enabled, else 7'h7F.
  - dp ← ~frame_dot[digit] if enabled, else 1.
  - Latency is 1 cycle from a state change to the pins.
- Output one-hotness: an never has more than one 0 bit; an is all-ones whenever the current digit is disabled.
- Hex decode (segments lit, gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Inputs are assumed synchronous to clk; no synchronizers are included.

Optional Feature:
- Macro: SEVEN_SEGMENT_GHOST_GUARD_EN.
- Defined: while cnt < GUARD_CYCLES, an is forced to 8'hFF, seg to 7'h7F and dp to 1 (registered, same 1-cycle latency). This suppresses ghosting on anode transitions.
- Undefined: no guard; GUARD_CYCLES is ignored; the behaviour is exactly as above.

Decomposition:
- Package seven_segment_pkg:
  - constants SEG_OFF = 7'h7F, AN_OFF = 8'hFF, N_DIGITS = 8;
  - function hex_to_segments(4-bit) returning active-high gfedcba.
- One natural sub-module: hex_to_seven_segment, a combinational decoder wrapping the package function. The mux instantiates it once on the selected nibble.

Test Plan:
- Reset hold and release (DIGIT_PERIOD=4): during reset and on the first post-release edge, an=FF, seg=7F, dp=1. On the next edge, with number=32'h0000_0001 and digit_en=01, expect an=FE and seg=~06=79.
- Full scan (DIGIT_PERIOD=4): number=76543210, digit_en=FF, dot=00.
  - an must cycle FE,FD,…,7F, 4 cycles each.
  - seg must equal ~decode(i) in each slot.
  - an wraps back to FE after slot 7.
- Frame coherence: change number from 0000_0000 to FFFF_FFFF while digit=3. Digits 3..7 must still show 0 (seg=40). Digit 0 of the next frame shows F (seg=0E).
- Masks: digit_en=0x05, dot=0x04. Only slots 0 and 2 assert an (FE, FB); dp=0 only in slot 2; all other slots give an=FF, seg=7F, dp=1.
- Reset mid-slot: assert reset at digit=5, cnt=2. Next edge gives an=FF and cnt=0; after release, scanning restarts at digit 0 with a fresh snapshot.
- Ghost guard (macro defined, DIGIT_PERIOD=8, GUARD_CYCLES=2): in each slot the first 2 output cycles are an=FF and seg=7F, the next 6 show the digit. With the macro undefined, all 8 cycles show the digit.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// Shared constants and the hex-to-segment table for the 8-digit seven-segment driver.
// Segment patterns are active-high in gfedcba order; the pins invert them.
package seven_segment_pkg;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [7:0] AN_OFF   = 8'hFF;
  localparam int         N_DIGITS = 8;

  function automatic logic [6:0] hex_to_segments(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex_to_seven_segment.sv
// Combinational hex nibble decoder; output is active-high gfedcba.
module hex_to_seven_segment
  import seven_segment_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = hex_to_segments(nibble);

endmodule

// File: rtl/seven_segment_8digit_mux.sv
// Time-multiplexed 8-digit common-anode seven-segment driver with per-frame input snapshot.
// Optional anode-transition blanking is enabled by defining SEVEN_SEGMENT_GHOST_GUARD_EN.
module seven_segment_8digit_mux
  import seven_segment_pkg::*;
#(
  parameter int DIGIT_PERIOD = 100000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] number,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dot,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an
);

  localparam int                CNT_W   = $clog2(DIGIT_PERIOD);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DIGIT_PERIOD - 1);
`ifdef SEVEN_SEGMENT_GHOST_GUARD_EN
  localparam bit                GUARD_ACTIVE = 1'b1;
`else
  localparam bit                GUARD_ACTIVE = 1'b0;
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       digit_q, digit_d;
  logic [31:0]      frame_num_q, frame_num_d;
  logic [7:0]       frame_en_q, frame_en_d;
  logic [7:0]       frame_dot_q, frame_dot_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [7:0]       an_q, an_d;

  logic [3:0]       nibble;
  logic [6:0]       seg_lit;
  logic             guard;

  hex_to_seven_segment u_decode (
    .nibble   (nibble),
    .segments (seg_lit)
  );

  always_comb begin
    nibble = frame_num_q[{digit_q, 2'b00} +: 4];
    guard  = GUARD_ACTIVE && (cnt_q < CNT_W'(GUARD_CYCLES));

    cnt_d   = cnt_q + 1'b1;
    digit_d = digit_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      digit_d = digit_q + 3'd1;
    end

    // Snapshot at the start of digit 0 so a whole refresh shows one value.
    frame_num_d = frame_num_q;
    frame_en_d  = frame_en_q;
    frame_dot_d = frame_dot_q;
    if (cnt_q == '0 && digit_q == 3'd0) begin
      frame_num_d = number;
      frame_en_d  = digit_en;
      frame_dot_d = dot;
    end

    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (frame_en_q[digit_q] && !guard) begin
      an_d  = ~(8'b1 << digit_q);
      seg_d = ~seg_lit;
      dp_d  = ~frame_dot_q[digit_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      digit_q     <= 3'd0;
      frame_num_q <= '0;
      frame_en_q  <= '0;
      frame_dot_q <= '0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      digit_q     <= digit_d;
      frame_num_q <= frame_num_d;
      frame_en_q  <= frame_en_d;
      frame_dot_q <= frame_dot_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seven_segment_8digit_mux.sv
// Self-checking bench for seven_segment_8digit_mux: directed scans plus randomized traffic
// against a slot/frame model derived from the elapsed cycle count since reset release.
module tb_seven_segment_8digit_mux;

  localparam int DP = 4;
  localparam int GC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] number = '0;
  logic [7:0]  digit_en = '0;
  logic [7:0]  dot = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;

  seven_segment_8digit_mux #(.DIGIT_PERIOD(DP), .GUARD_CYCLES(GC)) dut (
    .clk      (clk),
    .reset    (reset),
    .number   (number),
    .digit_en (digit_en),
    .dot      (dot),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          errors  = 0;
  int          n = 0;
  logic [31:0] m_num = '0;
  logic [7:0]  m_en  = '0;
  logic [7:0]  m_dot = '0;

  function automatic logic [6:0] ref_decode(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic int cur_digit();
    return (n / DP) % 8;
  endfunction

  function automatic int cur_cnt();
    return n % DP;
  endfunction

  // One clock edge: predict from the state before the edge, then compare after it.
  task automatic tick();
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int         d;
    bit         blank;
    e_an  = 8'hFF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    if (reset) begin
      n     = 0;
      m_num = '0;
      m_en  = '0;
      m_dot = '0;
    end else begin
      d = cur_digit();
`ifdef SEVEN_SEGMENT_GHOST_GUARD_EN
      blank = (cur_cnt() < GC);
`else
      blank = 1'b0;
`endif
      if (m_en[d] && !blank) begin
        e_an  = ~(8'h01 << d);
        e_seg = ~ref_decode(m_num[d*4 +: 4]);
        e_dp  = ~m_dot[d];
      end
      if (n % (8 * DP) == 0) begin
        m_num = number;
        m_en  = digit_en;
        m_dot = dot;
      end
      n++;
    end
    @(posedge clk);
    #1;
    vectors++;
    assert (an === e_an) else begin
      errors++;
      $error("FAIL an t=%0t observed=%h expected=%h", $time, an, e_an);
    end
    vectors++;
    assert (seg === e_seg) else begin
      errors++;
      $error("FAIL seg t=%0t observed=%h expected=%h", $time, seg, e_seg);
    end
    vectors++;
    assert (dp === e_dp) else begin
      errors++;
      $error("FAIL dp t=%0t observed=%b expected=%b", $time, dp, e_dp);
    end
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  // Advance until the model reaches the given digit/count (bounded by one frame).
  task automatic run_to(input int d, input int c);
    for (int i = 0; i < 8 * DP + 1; i++) begin
      if (cur_digit() == d && cur_cnt() == c) break;
      tick();
    end
  endtask

  initial begin
    // Reset hold with random inputs present
    number   = $urandom;
    digit_en = 8'($urandom);
    dot      = 8'($urandom);
    run(3);

    // Release: first edge still blank, then digit 0 shows '1'
    number   = 32'h0000_0001;
    digit_en = 8'h01;
    dot      = 8'h00;
    reset    = 1'b0;
    run(8 * DP + 4);

    // Full scan of 76543210
    number   = 32'h7654_3210;
    digit_en = 8'hFF;
    dot      = 8'h00;
    run(8 * DP * 3);

    // Frame coherence: value change mid-frame must wait for the next frame
    number = 32'h0000_0000;
    run(8 * DP);
    run_to(3, 1);
    number = 32'hFFFF_FFFF;
    run(8 * DP * 2);

    // Enable and decimal-point masks
    digit_en = 8'h05;
    dot      = 8'h04;
    run(8 * DP * 3);

    // Reset in the middle of slot 5, then restart with a fresh snapshot
    number   = 32'hA5C3_9E18;
    digit_en = 8'hFF;
    dot      = 8'hAA;
    run(8 * DP);
    run_to(5, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    number = 32'h1234_ABCD;
    run(8 * DP * 2);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        number   = $urandom;
        digit_en = 8'($urandom);
        dot      = 8'($urandom);
      end
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0;
    run(8 * DP);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
